// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_ctrl_if;
    logic        start_i;
    logic [12:0] muldiv_info_i;
    logic [63:0] rs1_data_i;
    logic [63:0] rs2_data_i;
    logic [4:0]  rd_id_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_id_o;

    modport master (
        output start_i, muldiv_info_i, rs1_data_i, rs2_data_i, rd_id_i, flush_i,
        input  busy_o, done_o, result_o, rd_id_o
    );
    modport slave (
        input  start_i, muldiv_info_i, rs1_data_i, rs2_data_i, rd_id_i, flush_i,
        output busy_o, done_o, result_o, rd_id_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV64 M-extension controller: shift-add multiplier and restoring divider, one bit per cycle,
// with sign fix-up and divide special cases resolved at accept time.
module muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

    state_t               state, next_state;
    logic [12:0]          op;
    logic [4:0]           rd;
    logic [6:0]           cnt;
    logic [2*XLEN-1:0]    acc;
    logic [2*XLEN-1:0]    mcand;
    logic [XLEN-1:0]      opb;
    logic                 neg_res, neg_a, special;
    logic [XLEN-1:0]      result;
    logic [4:0]           rd_out;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Request decode and operand preparation on the raw inputs
    logic [12:0]     in;
    logic            in_w, in_div, in_rem, in_sa, in_sb, onehot, accept;
    logic            a_neg, b_neg, div0, ovf, spec;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_val;

    always_comb begin
        in      = bus.muldiv_info_i;
        in_w    = in[8] | (|in[3:0]);
        in_div  = |in[7:0];
        in_rem  = in[5] | in[4] | in[1] | in[0];
        in_sa   = in[12] | in[11] | in[10] | in[8] | in[7] | in[5] | in[3] | in[1];
        in_sb   = in[12] | in[11] | in[8] | in[7] | in[5] | in[3] | in[1];
        onehot  = (in != 13'd0) && ((in & (in - 13'd1)) == 13'd0);
        accept  = (state == IDLE) && bus.start_i && !bus.flush_i && onehot;

        a_ext   = in_w ? {{(XLEN-32){in_sa & bus.rs1_data_i[31]}}, bus.rs1_data_i[31:0]}
                       : bus.rs1_data_i;
        b_ext   = in_w ? {{(XLEN-32){in_sb & bus.rs2_data_i[31]}}, bus.rs2_data_i[31:0]}
                       : bus.rs2_data_i;
        a_neg   = in_sa & a_ext[XLEN-1];
        b_neg   = in_sb & b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;

        min_val = in_w ? MIN_W : MIN_D;
        div0    = in_div && (b_ext == '0);
        ovf     = in_div && in_sa && (a_ext == min_val) && (b_ext == '1);
        spec    = div0 | ovf;
        if (div0)
            spec_val = in_rem ? (in_w ? sext32(bus.rs1_data_i[31:0]) : bus.rs1_data_i) : '1;
        else
            spec_val = in_rem ? '0 : min_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = spec ? FIXUP : CALC;
            CALC:  if (cnt == 7'd1) next_state = FIXUP;
            FIXUP: next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush_i && state != IDLE) next_state = IDLE;
    end

    // One restoring-divide step: remainder in acc[127:64], quotient shifts into acc[63:0]
    logic [XLEN:0] rem_sh, diff;
    always_comb begin
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff   = rem_sh - {1'b0, opb};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix;
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix  = '0;
        if (special)          fix = acc[XLEN-1:0];
        else if (op[12])      fix = prod[XLEN-1:0];
        else if (|op[11:9])   fix = prod[2*XLEN-1:XLEN];
        else if (op[8])       fix = sext32(prod[31:0]);
        else if (|op[7:6])    fix = quo;
        else if (|op[5:4])    fix = rmd;
        else if (|op[3:2])    fix = sext32(quo[31:0]);
        else if (|op[1:0])    fix = sext32(rmd[31:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op      <= '0;
            rd      <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            neg_a   <= 1'b0;
            special <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op      <= in;
                    rd      <= bus.rd_id_i;
                    cnt     <= in_w ? 7'd32 : 7'd64;
                    neg_a   <= a_neg;
                    neg_res <= a_neg ^ b_neg;
                    special <= spec;
                    opb     <= b_mag;
                    mcand   <= {{XLEN{1'b0}}, a_mag};
                    // W divides pre-shift the dividend so 32 steps consume exactly its bits
                    if (spec)        acc <= {{XLEN{1'b0}}, spec_val};
                    else if (in_div) acc <= {{XLEN{1'b0}}, in_w ? (a_mag << (XLEN/2)) : a_mag};
                    else             acc <= '0;
                end
                CALC: begin
                    cnt <= cnt - 7'd1;
                    if (|op[7:0]) begin
                        if (!diff[XLEN]) acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else             acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    end else begin
                        acc   <= acc + (opb[0] ? mcand : '0);
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                    end
                end
                FIXUP: if (!bus.flush_i) begin
                    result <= fix;
                    rd_out <= rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result;
    assign bus.rd_id_o  = rd_out;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table through a scoreboard queue plus
// hand-written flush, reject and reset sequences.
module tb_muldiv_ctrl;
    localparam logic [12:0] MUL = 13'h1000, MULH = 13'h0800, MULHSU = 13'h0400, MULHU = 13'h0200,
                            MULW = 13'h0100, DIV = 13'h0080, DIVU = 13'h0040, REM = 13'h0020,
                            REMU = 13'h0010, DIVW = 13'h0008, DIVUW = 13'h0004, REMW = 13'h0002,
                            REMUW = 13'h0001;

    typedef struct {
        logic [12:0] info;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] res;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] last_res = '0;
    logic [4:0]  last_rd = '0;
    exp_t sb[$];
    vec_t vecs[$];

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [12:0] info, input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] rd, input logic [63:0] res, input int lat,
                                input string name);
        vec_t v;
        v.info = info; v.a = a; v.b = b; v.rd = rd; v.res = res; v.lat = lat; v.name = name;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; the accept edge is the next posedge
    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        bus.start_i       = 1'b1;
        bus.muldiv_info_i = v.info;
        bus.rs1_data_i    = v.a;
        bus.rs2_data_i    = v.b;
        bus.rd_id_i       = v.rd;
        if (push) begin
            e.res = v.res; e.rd = v.rd; e.lat = v.lat; e.acc = cyc + 1; e.name = v.name;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        exp_t e;
        int   n = 0;
        int   gap = 0;
        while (sb.size() > 0 && n < budget) begin
            if (bus.done_o) begin
                e = sb.pop_front();
                chk({e.name, " result"}, bus.result_o, e.res);
                chk({e.name, " rd"}, 64'(bus.rd_id_o), 64'(e.rd));
                chk({e.name, " latency"}, 64'(cyc + 1 - e.acc), 64'(e.lat));
                chk({e.name, " busy_held"}, 64'(gap), 64'd0);
                last_res = e.res;
                last_rd  = e.rd;
                @(negedge clk);
                chk({e.name, " busy_fall"}, 64'(bus.busy_o), 64'd0);
                gap = 0;
            end else begin
                if (!bus.busy_o) gap++;
                @(negedge clk);
                n++;
            end
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), n);
            sb.delete();
        end
    endtask

    // Nothing may start or complete for n cycles
    task automatic expect_quiet(input string nm, input int n);
        int bad = 0;
        repeat (n) begin
            if (bus.done_o || bus.busy_o) bad++;
            @(negedge clk);
        end
        chk({nm, " quiet_cycles_bad"}, 64'(bad), 64'd0);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.muldiv_info_i = '0; bus.rs1_data_i = '0;
        bus.rs2_data_i = '0; bus.rd_id_i = '0; bus.flush_i = 1'b0;

        vecs.push_back(mk(MUL,    64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd1, 64'hFFFFFFFFFFFFFFEB, 66, "mul"));
        vecs.push_back(mk(DIV,    64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd2, 64'hFFFFFFFFFFFFFFFD, 66, "div"));
        vecs.push_back(mk(REM,    64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd3, 64'hFFFFFFFFFFFFFFFF, 66, "rem"));
        vecs.push_back(mk(DIVU,   64'h1234, 64'd0, 5'd4, 64'hFFFFFFFFFFFFFFFF, 2, "divu_by0"));
        vecs.push_back(mk(REMU,   64'h1234, 64'd0, 5'd5, 64'h1234, 2, "remu_by0"));
        vecs.push_back(mk(DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd6,
                          64'h8000000000000000, 2, "div_ovf"));
        vecs.push_back(mk(REM,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd7, 64'd0, 2, "rem_ovf"));
        vecs.push_back(mk(DIVW,   64'hAAAAAAAAFFFFFFF9, 64'd2, 5'd8, 64'hFFFFFFFFFFFFFFFD, 34, "divw"));
        vecs.push_back(mk(MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd9,
                          64'hFFFFFFFFFFFFFFFE, 66, "mulhu"));
        vecs.push_back(mk(MULH,   64'h8000000000000000, 64'd2, 5'd10, 64'hFFFFFFFFFFFFFFFF, 66, "mulh"));
        vecs.push_back(mk(MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd11,
                          64'hFFFFFFFFFFFFFFFF, 66, "mulhsu"));
        vecs.push_back(mk(MULW,   64'h1234567800000005, 64'h00000000FFFFFFFF, 5'd12,
                          64'hFFFFFFFFFFFFFFFB, 34, "mulw"));
        vecs.push_back(mk(DIVU,   64'd100, 64'd7, 5'd13, 64'd14, 66, "divu"));
        vecs.push_back(mk(REMUW,  64'h00000000FFFFFFFF, 64'd10, 5'd14, 64'd5, 34, "remuw"));
        vecs.push_back(mk(DIVUW,  64'hFFFFFFFFFFFFFFFF, 64'h10, 5'd15, 64'h000000000FFFFFFF, 34, "divuw"));
        vecs.push_back(mk(REMW,   64'h0000000080000001, 64'hFFFFFFFF00000000, 5'd16,
                          64'hFFFFFFFF80000001, 2, "remw_by0"));
        vecs.push_back(mk(DIVW,   64'h0000000080000000, 64'h00000000FFFFFFFF, 5'd17,
                          64'hFFFFFFFF80000000, 2, "divw_ovf"));
        vecs.push_back(mk(REM,    64'd7, 64'hFFFFFFFFFFFFFFFE, 5'd18, 64'd1, 66, "rem_negdiv"));
        vecs.push_back(mk(DIV,    64'hFFFFFFFFFFFFFFFB, 64'd0, 5'd19, 64'hFFFFFFFFFFFFFFFF, 2, "div_by0"));

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bus.busy_o), 64'd0);
        chk("reset done", 64'(bus.done_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        chk("reset rd", 64'(bus.rd_id_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1);
            wait_done(200);
        end

        // start_i while busy must not disturb the running op
        issue(mk(MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd20, 64'hFFFFFFFFFFFFFFEB, 66, "busy_start"), 1'b1);
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1; bus.muldiv_info_i = DIVU; bus.rs1_data_i = 64'h1234;
        bus.rs2_data_i = 64'd0; bus.rd_id_i = 5'd31;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(200);
        expect_quiet("after_busy_start", 10);

        // Multi-hot, zero-hot and flush-in-IDLE requests are dropped
        bus.start_i = 1'b1; bus.muldiv_info_i = MUL | DIV; bus.rs1_data_i = 64'd7; bus.rs2_data_i = 64'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        expect_quiet("multihot", 80);
        bus.start_i = 1'b1; bus.muldiv_info_i = 13'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        expect_quiet("zerohot", 5);
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.muldiv_info_i = DIVU; bus.rs2_data_i = 64'd0;
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        expect_quiet("flush_idle", 5);

        // Flush 10 cycles into a divide
        issue(mk(DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd9, 64'd0, 66, "flushed"), 1'b0);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush busy", 64'(bus.busy_o), 64'd0);
        chk("flush rd_kept", 64'(bus.rd_id_o), 64'(last_rd));
        chk("flush result_kept", bus.result_o, last_res);
        expect_quiet("after_flush", 80);

        // Asynchronous reset mid-CALC
        issue(mk(MUL, 64'd3, 64'd5, 5'd22, 64'd15, 66, "reset_mid"), 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset busy", 64'(bus.busy_o), 64'd0);
        chk("midreset done", 64'(bus.done_o), 64'd0);
        chk("midreset result", bus.result_o, 64'd0);
        chk("midreset rd", 64'(bus.rd_id_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(vecs[7], 1'b1);
        wait_done(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
